// File: rtl/sfp_id_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : sfp_id_pkg
//  Brief   : Shared FSM state encodings and width helper for the SFP ID
//            multi-channel reader.
//  Rev     : 1.0  initial release
// ============================================================================
package sfp_id_pkg;

  // Reader FSM state encodings
  localparam logic [1:0] s_Idle     = 2'd0;
  localparam logic [1:0] s_WbStart  = 2'd1;
  localparam logic [1:0] s_WbClose  = 2'd2;
  localparam logic [1:0] s_Done     = 2'd3;

  // Ceiling log2 that never returns less than one bit, so counters and
  // indices stay legal when a parameter is 1.
  function automatic int unsigned clog2_min1(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage : sfp_id_pkg
`default_nettype wire

// File: rtl/sfp_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : sfp_rr_arbiter
//  Brief   : Combinational round-robin arbiter. Searches the request vector
//            starting at the channel after 'last' and wrapping around;
//            returns a one-hot grant, its index and an any-request flag.
//  Rev     : 1.0  initial release
// ============================================================================
module sfp_rr_arbiter
  import sfp_id_pkg::*;
#(
  parameter int unsigned g_Channels = 2
) (
  input  logic [g_Channels-1:0]                request,
  input  logic [clog2_min1(g_Channels)-1:0]    last,
  output logic [g_Channels-1:0]                grant,
  output logic [clog2_min1(g_Channels)-1:0]    index,
  output logic                                 any
);

  localparam int unsigned IDX_W = clog2_min1(g_Channels);

  logic [IDX_W-1:0] cand;

  // First requester found walking upward from last+1 (mod channel count) wins
  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= g_Channels; k++) begin
      cand = IDX_W'((32'(last) + k) % g_Channels);
      if (!any && request[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        index       = cand;
      end
    end
  end

endmodule : sfp_rr_arbiter
`default_nettype wire

// File: rtl/sfp_id_multi_reader.sv
`default_nettype none
// ============================================================================
//  Module  : sfp_id_multi_reader
//  Brief   : Scans up to 8 SFP cages and reads a block of EEPROM ID bytes
//            from each newly plugged module over a classic Wishbone master
//            port. Results are latched per channel with valid/error flags.
//  Rev     : 1.0  initial release
// ============================================================================
module sfp_id_multi_reader
  import sfp_id_pkg::*;
#(
  parameter int unsigned g_Channels         = 2,
  parameter int unsigned g_SfpWbBaseAddress = 0,
  parameter int unsigned g_ChannelStride    = 256,
  parameter int unsigned g_StartOffset      = 40,
  parameter int unsigned g_NumBytes         = 16,
  parameter int unsigned g_TimeoutCycles    = 4096,
  parameter int unsigned g_WbAddrWidth      = 32
) (
  input  logic                                  Clk_ik,
  input  logic                                  Rst_ir,
  input  logic [g_Channels-1:0]                 SfpPlugged_ib,
  output logic [g_Channels-1:0]                 SfpIdValid_ob,
  output logic [g_Channels-1:0]                 SfpIdError_ob,
  output logic [g_Channels*g_NumBytes*8-1:0]    SfpId_ob,
  output logic                                  WbCyc_o,
  output logic                                  WbStb_o,
  output logic [g_WbAddrWidth-1:0]              WbAddr_ob,
  input  logic [7:0]                            WbData_ib8,
  input  logic                                  WbAck_i
);

  localparam int unsigned IDX_W   = clog2_min1(g_Channels);
  localparam int unsigned CNT_W   = clog2_min1(g_NumBytes);
  localparam int unsigned TMO_W   = clog2_min1(g_TimeoutCycles);
  localparam int unsigned SLICE_W = g_NumBytes * 8;
  localparam int unsigned AW      = g_WbAddrWidth;

  localparam logic [CNT_W-1:0] LAST_BYTE   = CNT_W'(g_NumBytes - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(g_TimeoutCycles - 1);
  localparam logic [IDX_W-1:0] LAST_CH     = IDX_W'(g_Channels - 1);
  localparam logic [AW-1:0]    BASE_ADDR   = AW'(g_SfpWbBaseAddress);
  localparam logic [AW-1:0]    STRIDE      = AW'(g_ChannelStride);
  localparam logic [AW-1:0]    START_OFS   = AW'(g_StartOffset);

  logic [1:0]            state;
  logic [IDX_W-1:0]      active_ch;
  logic [IDX_W-1:0]      rr_last;
  logic [CNT_W-1:0]      byte_cnt;
  logic [TMO_W-1:0]      tmo_cnt;

  logic [g_Channels-1:0] pending;
  logic [g_Channels-1:0] grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [AW-1:0]         start_addr;
  logic                  active_plugged;
  logic [SLICE_W-1:0]    cur_slice;
  logic [SLICE_W-1:0]    shifted_slice;

  // A channel wants service while present and neither captured nor failed
  always_comb begin
    pending = SfpPlugged_ib & ~SfpIdValid_ob & ~SfpIdError_ob;
  end

  sfp_rr_arbiter #(
    .g_Channels (g_Channels)
  ) u_arbiter (
    .request (pending),
    .last    (rr_last),
    .grant   (grant),
    .index   (grant_idx),
    .any     (grant_any)
  );

  // Per-channel address and data helpers for the channel being serviced
  always_comb begin
    start_addr     = BASE_ADDR + STRIDE * AW'(grant_idx) + START_OFS;
    active_plugged = SfpPlugged_ib[active_ch];
    cur_slice      = SfpId_ob[active_ch*SLICE_W +: SLICE_W];
    shifted_slice  = (cur_slice << 8) | SLICE_W'(WbData_ib8);
  end

  // Wishbone strobes follow the FSM state directly so aborts drop them at once
  always_comb begin
    WbCyc_o = (state == s_WbStart) || (state == s_WbClose);
    WbStb_o = (state == s_WbStart);
  end

  // Reader FSM, round-robin pointer and per-channel result registers
  always_ff @(posedge Clk_ik) begin
    if (Rst_ir) begin
      state         <= s_Idle;
      active_ch     <= '0;
      rr_last       <= LAST_CH;
      byte_cnt      <= '0;
      tmo_cnt       <= '0;
      WbAddr_ob     <= BASE_ADDR;
      SfpIdValid_ob <= '0;
      SfpIdError_ob <= '0;
      SfpId_ob      <= '0;
    end else begin
      case (state)
        s_Idle: begin
          if (grant_any) begin
            state     <= s_WbStart;
            active_ch <= grant_idx;
            rr_last   <= grant_idx;
            byte_cnt  <= '0;
            tmo_cnt   <= '0;
            WbAddr_ob <= start_addr;
          end
        end

        s_WbStart: begin
          if (!active_plugged) begin
            state <= s_Idle;
          end else if (WbAck_i) begin
            // An ack in the expiry cycle still wins over the timeout
            SfpId_ob[active_ch*SLICE_W +: SLICE_W] <= shifted_slice;
            state <= s_WbClose;
          end else if (tmo_cnt == TMO_LAST) begin
            SfpIdError_ob[active_ch]               <= 1'b1;
            SfpId_ob[active_ch*SLICE_W +: SLICE_W] <= '0;
            state <= s_Idle;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end

        s_WbClose: begin
          if (!active_plugged) begin
            state <= s_Idle;
          end else if (!WbAck_i) begin
            if (byte_cnt == LAST_BYTE) begin
              state <= s_Done;
            end else begin
              byte_cnt  <= byte_cnt + CNT_W'(1);
              WbAddr_ob <= WbAddr_ob + AW'(1);
              tmo_cnt   <= '0;
              state     <= s_WbStart;
            end
          end
        end

        s_Done: begin
          if (active_plugged) begin
            SfpIdValid_ob[active_ch] <= 1'b1;
          end
          state <= s_Idle;
        end

        default: begin
          state <= s_Idle;
        end
      endcase

      // Unplug wipes a channel; a newly granted channel starts from a clean slice
      for (int unsigned c = 0; c < g_Channels; c++) begin
        if (!SfpPlugged_ib[c]) begin
          SfpIdValid_ob[c]                <= 1'b0;
          SfpIdError_ob[c]                <= 1'b0;
          SfpId_ob[c*SLICE_W +: SLICE_W]  <= '0;
        end else if ((state == s_Idle) && grant[c]) begin
          SfpId_ob[c*SLICE_W +: SLICE_W]  <= '0;
        end
      end
    end
  end

endmodule : sfp_id_multi_reader
`default_nettype wire

// File: doc/sfp_id_multi_reader.md
SFP_ID_MULTI_READER -- requirements
Module: sfp_id_multi_reader

Interface
REQ-001 Parameter g_Channels, default 2: number of SFP cages scanned, legal 1..8.
REQ-002 Parameter g_SfpWbBaseAddress, default 0: WB byte address of channel 0 EEPROM byte 0.
REQ-003 Parameter g_ChannelStride, default 256: WB address distance between consecutive channels' EEPROM windows.
REQ-004 Parameter g_StartOffset, default 40: first EEPROM byte read per channel (vendor PN).
REQ-005 Parameter g_NumBytes, default 16: bytes read per channel, legal 1..32.
REQ-006 Parameter g_TimeoutCycles, default 4096: max cycles waiting for WbAck_i before a byte read fails.
REQ-007 Parameter g_WbAddrWidth, default 32: WB address width.
REQ-008 Clk_ik  in  1  single clock; all logic on rising edge.
REQ-009 Rst_ir  in  1  reset, synchronous, active-high.
REQ-010 SfpPlugged_ib  in  g_Channels  per-channel module-present, already synchronous to Clk_ik.
REQ-011 SfpIdValid_ob  out  g_Channels  per-channel ID captured successfully.
REQ-012 SfpIdError_ob  out  g_Channels  per-channel read failed (timeout).
REQ-013 SfpId_ob  out  g_Channels*g_NumBytes*8  channel c occupies slice [c*g_NumBytes*8 +: g_NumBytes*8].
REQ-014 WbCyc_o, WbStb_o  out  1 each  WB classic master strobes.
REQ-015 WbAddr_ob  out  g_WbAddrWidth  WB byte address.
REQ-016 WbData_ib8  in  8  read data, sampled with WbAck_i.
REQ-017 WbAck_i  in  1  WB acknowledge.

Function
REQ-018 Channel c is pending when SfpPlugged_ib[c]=1 and SfpIdValid_ob[c]=0 and SfpIdError_ob[c]=0.
REQ-019 FSM states: s_Idle, s_WbStart, s_WbClose, s_Done; Idle selects next pending channel round-robin starting after the last serviced one.
REQ-020 s_Idle -> s_WbStart when any channel pending; byte counter=0, WbAddr_ob=g_SfpWbBaseAddress+c*g_ChannelStride+g_StartOffset.
REQ-021 s_WbStart: WbCyc_o=WbStb_o=1; on WbAck_i=1 capture WbData_ib8 and go s_WbClose.
REQ-022 Captured bytes shift in from LSB; first byte read ends in the channel slice MSByte.
REQ-023 s_WbClose: WbStb_o=0, WbCyc_o=1; wait WbAck_i=0, then if byte counter=g_NumBytes-1 go s_Done, else increment counter and address, go s_WbStart.
REQ-024 s_Done: WbCyc_o=WbStb_o=0, set SfpIdValid_ob[c] for one-cycle-later visibility, return to s_Idle next cycle.
REQ-025 Timeout counter clears on entry to s_WbStart; reaching g_TimeoutCycles without ack sets SfpIdError_ob[c], clears that channel slice, drops WbCyc_o/WbStb_o, goes s_Idle.
REQ-026 No retry of an errored channel until it is unplugged and replugged.
REQ-027 SfpPlugged_ib[c]=0 on any channel clears its Valid, Error and slice next cycle.
REQ-028 Unplug of the channel being read aborts: WbCyc_o/WbStb_o=0 next cycle, FSM to s_Idle, no flags set.
REQ-029 Ack arriving in the same cycle as timeout expiry counts as ack (data accepted).
REQ-030 Slice of a channel is updated only while it is the active channel; other slices hold.
REQ-031 Byte counter width clog2(g_NumBytes) bits minimum; address arithmetic done at g_WbAddrWidth, wraps modulo 2^g_WbAddrWidth.

Reset
REQ-032 Rst_ir=1: FSM s_Idle, round-robin pointer to channel g_Channels-1 (so channel 0 first), all Valid/Error/SfpId_ob=0, WbCyc_o=WbStb_o=0, WbAddr_ob=g_SfpWbBaseAddress.
REQ-033 Reset mid-transfer drops WbCyc_o/WbStb_o on the next edge; no partial data retained.

Structure
REQ-034 State encodings and width helper (clog2) reside in shared package sfp_id_pkg.
REQ-035 Round-robin pending-channel arbiter is sub-module sfp_rr_arbiter (request vector in, one-hot grant plus index out).

Verification
REQ-036 Ch0 plugged, slave acks in 2 cycles with data=offset low byte -> 16 reads at addr 40..55, SfpId_ob ch0 = 0x28292A..37, Valid[0]=1.
REQ-037 Ch0 and ch1 plugged same cycle -> ch0 fully read first, then ch1 at addr 296..311, both Valid.
REQ-038 Slave never acks on ch1 -> Cyc drops after 4096 cycles, Error[1]=1, slice 0; replug ch1 with acking slave -> Valid[1]=1, Error[1]=0.
REQ-039 Ch0 unplugged after byte 5 -> Cyc=0 next cycle, Valid[0]=0, slice 0; replug -> full re-read from addr 40.
REQ-040 Rst_ir pulsed mid-byte-8 -> Cyc/Stb=0 next edge, all outputs 0, rescan from channel 0 after release.
